// File: rtl/be8_pkg.sv
// Shared definitions for the be8 CPU slice: bus widths, arbiter state encoding
// and a small saturating-counter helper.
package be8_pkg;

  localparam int RAM_AW = 4;
  localparam int DW     = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_ACK   = 2'd2
  } arb_state_e;

  // Three-bit increment that sticks at its maximum value.
  function automatic logic [2:0] sat_inc3(input logic [2:0] value);
    logic [2:0] result;
    if (value == 3'd7) begin
      result = value;
    end else begin
      result = value + 3'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Host-side four-phase access port into the shared program/data RAM.
interface ram_arbiter_if;
  import be8_pkg::*;

  logic              host_req;
  logic              host_we;
  logic [RAM_AW-1:0] host_addr;
  logic [DW-1:0]     host_wdata;
  logic              host_ack;
  logic [DW-1:0]     host_rdata;

  // The host (loader / debugger) drives requests.
  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata
  );

  // The arbiter answers them.
  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata
  );

endinterface

// File: rtl/ram_arbiter.sv
// Arbitrates the 16-byte RAM between the CPU microcode path and the host port.
// Owns the MAR, only grants the host at instruction boundaries (T0), freezes the
// CPU through HOLD, and enforces a minimum number of CPU instructions between
// host accesses unless the CPU is halted.
module ram_arbiter
  import be8_pkg::*;
#(
  parameter int MIN_CPU_INSTR = 1
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              T0,
  input  logic              HLT,
  input  logic              MIn,
  input  logic              RI,
  input  logic [DW-1:0]     BUS,
  output logic              HOLD,
  ram_arbiter_if.slave      host,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata
);

  localparam logic [2:0] MIN_CNT = 3'(MIN_CPU_INSTR);

  arb_state_e        state_r;
  arb_state_e        next_s;
  logic [RAM_AW-1:0] mar_r;
  logic              req_we_r;
  logic [RAM_AW-1:0] req_addr_r;
  logic [DW-1:0]     req_wdata_r;
  logic [2:0]        fair_cnt_r;
  logic              t0_prev_r;
  logic              hold_r;
  logic              ack_r;
  logic [DW-1:0]     rdata_r;
  logic              fair_ok_s;
  logic              grant_s;
  logic              release_s;
  logic              instr_start_s;

  assign fair_ok_s     = (fair_cnt_r >= MIN_CNT);
  assign instr_start_s = T0 && !t0_prev_r;
  assign grant_s       = (state_r == ARB_IDLE) && (next_s == ARB_GRANT);
  assign release_s     = (state_r == ARB_ACK) && (next_s == ARB_IDLE);

  assign HOLD            = hold_r;
  assign host.host_ack   = ack_r;
  assign host.host_rdata = rdata_r;

  // State register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode and RAM port steering (CPU path unless the host owns GRANT).
  always_comb begin
    next_s    = state_r;
    ram_addr  = mar_r;
    ram_we    = RI;
    ram_wdata = BUS;
    case (state_r)
      ARB_IDLE: begin
        if (host.host_req && T0 && (fair_ok_s || HLT)) begin
          next_s = ARB_GRANT;
        end else begin
          next_s = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        next_s    = ARB_ACK;
        ram_addr  = req_addr_r;
        ram_we    = req_we_r;
        ram_wdata = req_wdata_r;
      end
      ARB_ACK: begin
        if (!host.host_req) begin
          next_s = ARB_IDLE;
        end else begin
          next_s = ARB_ACK;
        end
      end
      default: begin
        next_s = ARB_IDLE;
      end
    endcase
  end

  // MAR: loaded by the CPU only while it is not frozen (the grant edge still counts as running).
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      mar_r <= 4'h0;
    end else if ((state_r == ARB_IDLE) && !MIn) begin
      mar_r <= BUS[RAM_AW-1:0];
    end
  end

  // Capture the host request at the grant decision so the host may change its lines afterwards.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      req_we_r    <= 1'b0;
      req_addr_r  <= 4'h0;
      req_wdata_r <= 8'h00;
    end else if (grant_s) begin
      req_we_r    <= host.host_we;
      req_addr_r  <= host.host_addr;
      req_wdata_r <= host.host_wdata;
    end
  end

  // Previous-edge T0, used to detect the start of each CPU instruction.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      t0_prev_r <= 1'b1;
    end else begin
      t0_prev_r <= T0;
    end
  end

  // Fairness counter: cleared on host release, counts instruction starts, saturates at 7.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      fair_cnt_r <= 3'd7;
    end else if (release_s) begin
      fair_cnt_r <= 3'd0;
    end else if (instr_start_s) begin
      fair_cnt_r <= sat_inc3(fair_cnt_r);
    end
  end

  // HOLD and acknowledge follow the state the arbiter is entering.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      hold_r <= 1'b0;
      ack_r  <= 1'b0;
    end else begin
      hold_r <= (next_s != ARB_IDLE);
      ack_r  <= (next_s == ARB_ACK);
    end
  end

  // Read data captured on GRANT exit for reads; held until the next read completes.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rdata_r <= 8'h00;
    end else if ((state_r == ARB_GRANT) && !req_we_r) begin
      rdata_r <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 16x8 RAM.
module tb_ram_arbiter;
  import be8_pkg::*;

  logic       clk;
  logic       RESETn;
  logic       T0;
  logic       HLT;
  logic       MIn;
  logic       RI;
  logic [7:0] BUS;
  logic       HOLD;
  logic [3:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic [7:0] mem [16];

  int vectors;
  int miscompares;

  ram_arbiter_if hif ();

  ram_arbiter #(.MIN_CPU_INSTR(2)) dut (
    .CLK       (clk),
    .RESETn    (RESETn),
    .T0        (T0),
    .HLT       (HLT),
    .MIn       (MIn),
    .RI        (RI),
    .BUS       (BUS),
    .HOLD      (HOLD),
    .host      (hif),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: asynchronous read, write on rising edge.
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_set(input logic req, input logic we, input logic [3:0] a, input logic [7:0] d);
    hif.host_req   = req;
    hif.host_we    = we;
    hif.host_addr  = a;
    hif.host_wdata = d;
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    #12;
    vectors++; if (HOLD !== 1'b0) begin miscompares++; $display("FAIL reset_hold: got %b want 0", HOLD); end
    vectors++; if (hif.host_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", hif.host_ack); end
    vectors++; if (hif.host_rdata !== 8'h00) begin miscompares++; $display("FAIL reset_rdata: got %h want 00", hif.host_rdata); end
    vectors++; if (ram_addr !== 4'h0) begin miscompares++; $display("FAIL reset_mar: got %h want 0", ram_addr); end
    @(negedge clk);
    RESETn = 1'b1;
    tick();
  endtask

  task automatic test_host_write_read();
    host_set(1'b1, 1'b1, 4'h3, 8'hA5);
    tick();
    vectors++; if (HOLD !== 1'b1) begin miscompares++; $display("FAIL wr_hold: got %b want 1", HOLD); end
    vectors++; if (ram_we !== 1'b1) begin miscompares++; $display("FAIL wr_ram_we: got %b want 1", ram_we); end
    vectors++; if (ram_addr !== 4'h3) begin miscompares++; $display("FAIL wr_ram_addr: got %h want 3", ram_addr); end
    vectors++; if (ram_wdata !== 8'hA5) begin miscompares++; $display("FAIL wr_ram_wdata: got %h want a5", ram_wdata); end
    vectors++; if (hif.host_ack !== 1'b0) begin miscompares++; $display("FAIL wr_ack_early: got %b want 0", hif.host_ack); end
    tick();
    vectors++; if (hif.host_ack !== 1'b1) begin miscompares++; $display("FAIL wr_ack: got %b want 1", hif.host_ack); end
    vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL wr_we_one_cycle: got %b want 0", ram_we); end
    vectors++; if (mem[3] !== 8'hA5) begin miscompares++; $display("FAIL wr_mem3: got %h want a5", mem[3]); end
    tick();
    vectors++; if (HOLD !== 1'b1) begin miscompares++; $display("FAIL wr_hold_while_req: got %b want 1", HOLD); end
    hif.host_req = 1'b0;
    tick();
    vectors++; if (HOLD !== 1'b0) begin miscompares++; $display("FAIL wr_release_hold: got %b want 0", HOLD); end
    vectors++; if (hif.host_ack !== 1'b0) begin miscompares++; $display("FAIL wr_release_ack: got %b want 0", hif.host_ack); end
    // Two instruction starts to satisfy MIN_CPU_INSTR=2.
    T0 = 1'b0; tick(); T0 = 1'b1; tick();
    T0 = 1'b0; tick(); T0 = 1'b1; tick();
    host_set(1'b1, 1'b0, 4'h3, 8'h00);
    tick();
    vectors++; if (HOLD !== 1'b1) begin miscompares++; $display("FAIL rd_hold: got %b want 1", HOLD); end
    vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL rd_ram_we: got %b want 0", ram_we); end
    tick();
    vectors++; if (hif.host_ack !== 1'b1) begin miscompares++; $display("FAIL rd_ack: got %b want 1", hif.host_ack); end
    vectors++; if (hif.host_rdata !== 8'hA5) begin miscompares++; $display("FAIL rd_rdata: got %h want a5", hif.host_rdata); end
    hif.host_req = 1'b0;
    tick();
  endtask

  task automatic test_wait_for_t0();
    T0 = 1'b0; tick(); T0 = 1'b1; tick();
    T0 = 1'b0; tick(); T0 = 1'b1; tick();
    T0 = 1'b0; tick();
    host_set(1'b1, 1'b1, 4'h9, 8'h77);
    MIn = 1'b0; BUS = 8'h07;
    tick();
    vectors++; if (HOLD !== 1'b0) begin miscompares++; $display("FAIL t0_hold_step: got %b want 0", HOLD); end
    vectors++; if (ram_addr !== 4'h7) begin miscompares++; $display("FAIL t0_mar: got %h want 7", ram_addr); end
    MIn = 1'b1; RI = 1'b1; BUS = 8'h42;
    #1;
    vectors++; if (ram_we !== 1'b1 || ram_wdata !== 8'h42) begin miscompares++; $display("FAIL t0_cpu_write: got we=%b d=%h want we=1 d=42", ram_we, ram_wdata); end
    tick();
    vectors++; if (HOLD !== 1'b0) begin miscompares++; $display("FAIL t0_hold_step3: got %b want 0", HOLD); end
    vectors++; if (mem[7] !== 8'h42) begin miscompares++; $display("FAIL t0_mem7: got %h want 42", mem[7]); end
    RI = 1'b0; T0 = 1'b1;
    tick();
    vectors++; if (HOLD !== 1'b1) begin miscompares++; $display("FAIL t0_grant_hold: got %b want 1", HOLD); end
    vectors++; if (ram_addr !== 4'h9 || ram_we !== 1'b1) begin miscompares++; $display("FAIL t0_grant_ram: got a=%h we=%b want a=9 we=1", ram_addr, ram_we); end
    tick();
    vectors++; if (hif.host_ack !== 1'b1) begin miscompares++; $display("FAIL t0_ack: got %b want 1", hif.host_ack); end
    vectors++; if (hif.host_rdata !== 8'hA5) begin miscompares++; $display("FAIL t0_rdata_hold: got %h want a5", hif.host_rdata); end
    vectors++; if (mem[9] !== 8'h77) begin miscompares++; $display("FAIL t0_mem9: got %h want 77", mem[9]); end
    hif.host_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    host_set(1'b1, 1'b0, 4'h9, 8'h00);
    tick();
    vectors++; if (HOLD !== 1'b0) begin miscompares++; $display("FAIL b2b_hold0: got %b want 0", HOLD); end
    T0 = 1'b0; tick();
    T0 = 1'b1; tick();
    vectors++; if (HOLD !== 1'b0) begin miscompares++; $display("FAIL b2b_hold1: got %b want 0", HOLD); end
    T0 = 1'b0; tick();
    T0 = 1'b1; tick();
    vectors++; if (HOLD !== 1'b0) begin miscompares++; $display("FAIL b2b_hold2: got %b want 0", HOLD); end
    tick();
    vectors++; if (HOLD !== 1'b1) begin miscompares++; $display("FAIL b2b_grant: got %b want 1", HOLD); end
    vectors++; if (ram_addr !== 4'h9) begin miscompares++; $display("FAIL b2b_addr: got %h want 9", ram_addr); end
    tick();
    vectors++; if (hif.host_rdata !== 8'h77) begin miscompares++; $display("FAIL b2b_rdata: got %h want 77", hif.host_rdata); end
    hif.host_req = 1'b0;
    tick();
  endtask

  task automatic test_hlt();
    HLT = 1'b1;
    host_set(1'b1, 1'b0, 4'h7, 8'h00);
    tick();
    vectors++; if (HOLD !== 1'b1) begin miscompares++; $display("FAIL hlt_grant: got %b want 1", HOLD); end
    tick();
    vectors++; if (hif.host_ack !== 1'b1 || hif.host_rdata !== 8'h42) begin miscompares++; $display("FAIL hlt_read: got ack=%b d=%h want ack=1 d=42", hif.host_ack, hif.host_rdata); end
    hif.host_req = 1'b0; HLT = 1'b0;
    tick();
    vectors++; if (HOLD !== 1'b0) begin miscompares++; $display("FAIL hlt_release: got %b want 0", HOLD); end
  endtask

  task automatic test_min_at_grant();
    HLT = 1'b1;
    host_set(1'b1, 1'b1, 4'h5, 8'h11);
    MIn = 1'b0; BUS = 8'h3C;
    tick();
    vectors++; if (ram_addr !== 4'h5) begin miscompares++; $display("FAIL min_grant_addr: got %h want 5", ram_addr); end
    BUS = 8'h05;
    tick();
    MIn = 1'b1; BUS = 8'h99;
    #1;
    vectors++; if (ram_addr !== 4'hC) begin miscompares++; $display("FAIL min_ack_mar: got %h want c", ram_addr); end
    hif.host_req = 1'b0; HLT = 1'b0;
    tick();
    vectors++; if (ram_addr !== 4'hC) begin miscompares++; $display("FAIL min_idle_mar: got %h want c", ram_addr); end
    vectors++; if (mem[5] !== 8'h11) begin miscompares++; $display("FAIL min_mem5: got %h want 11", mem[5]); end
  endtask

  task automatic test_reset_in_ack();
    HLT = 1'b1;
    host_set(1'b1, 1'b0, 4'h5, 8'h00);
    tick();
    tick();
    vectors++; if (hif.host_ack !== 1'b1 || hif.host_rdata !== 8'h11) begin miscompares++; $display("FAIL rst_pre_ack: got ack=%b d=%h want ack=1 d=11", hif.host_ack, hif.host_rdata); end
    RESETn = 1'b0;
    #1;
    vectors++; if (HOLD !== 1'b0 || hif.host_ack !== 1'b0) begin miscompares++; $display("FAIL rst_async: got hold=%b ack=%b want 0 0", HOLD, hif.host_ack); end
    vectors++; if (ram_addr !== 4'h0 || hif.host_rdata !== 8'h00) begin miscompares++; $display("FAIL rst_async_mar: got a=%h d=%h want 0 00", ram_addr, hif.host_rdata); end
    hif.host_req = 1'b0; HLT = 1'b0;
    #1;
    RESETn = 1'b1;
    tick();
    host_set(1'b1, 1'b0, 4'h3, 8'h00);
    tick();
    vectors++; if (HOLD !== 1'b1) begin miscompares++; $display("FAIL rst_next_grant: got %b want 1", HOLD); end
    tick();
    vectors++; if (hif.host_ack !== 1'b1 || hif.host_rdata !== 8'hA5) begin miscompares++; $display("FAIL rst_next_read: got ack=%b d=%h want ack=1 d=a5", hif.host_ack, hif.host_rdata); end
    hif.host_req = 1'b0;
    tick();
    vectors++; if (HOLD !== 1'b0 || hif.host_ack !== 1'b0) begin miscompares++; $display("FAIL rst_next_release: got hold=%b ack=%b want 0 0", HOLD, hif.host_ack); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    T0 = 1'b1; HLT = 1'b0; MIn = 1'b1; RI = 1'b0; BUS = 8'h00;
    host_set(1'b0, 1'b0, 4'h0, 8'h00);
    test_reset();
    test_host_write_read();
    test_wait_for_t0();
    test_back_to_back();
    test_hlt();
    test_min_at_grant();
    test_reset_in_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
